// File: rtl/tsc_link_pkg.sv
// tsc_link_pkg: shared TSC capture link line constants and hub receiver state encoding
package tsc_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_CD,
        HUNT,
        DATA,
        DONE
    } rx_state_t;

    localparam logic SD_IDLE       = 1'b1;
    localparam logic SD_START      = 1'b0;
    localparam logic CD_ACTIVE     = 1'b0;
    localparam int   BITS_PER_BYTE = 8;

    localparam int DEFAULT_DEPTH      = 32;
    localparam int DEFAULT_CD_TIMEOUT = 64;

endpackage

// File: rtl/rx_buffer_ram.sv
// rx_buffer_ram: DEPTH x 8 receive buffer, one write port, registered read port (read-before-write)
module rx_buffer_ram #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_data <= 8'h00;
        else
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/tsc_hub_rx.sv
// tsc_hub_rx: hub-side TSC capture receiver; TRD edge -> SBF request, then SD bytes into a local buffer until CD returns high
module tsc_hub_rx
    import tsc_link_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int CD_TIMEOUT = DEFAULT_CD_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              TRD,
    input  logic              SD,
    input  logic              CD,
    output logic              SBF,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [ADDR_W:0]   byte_count,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic              frame_err,
    output logic              timeout_err
);

    localparam int T_W = $clog2(CD_TIMEOUT + 1);

    rx_state_t         state, next;
    logic              trd_q;
    logic [T_W-1:0]    timer;
    logic [2:0]        bit_cnt;
    logic [6:0]        shreg;
    logic [ADDR_W-1:0] wr_ptr;
    logic              cd_active, timer_last, bit_last, full, wr_en;
    logic [7:0]        wr_data;

    assign cd_active  = CD == CD_ACTIVE;
    assign timer_last = timer == T_W'(CD_TIMEOUT - 1);
    assign bit_last   = bit_cnt == 3'(BITS_PER_BYTE - 1);
    assign full       = byte_count == (ADDR_W + 1)'(DEPTH);
    assign wr_data    = {SD, shreg};
    assign wr_en      = state == DATA && cd_active && bit_last && !full;

    assign SBF        = state == REQ;
    assign busy       = state != IDLE;
    assign frame_done = state == DONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (TRD && !trd_q && en) next = REQ;
            REQ:     next = WAIT_CD;
            WAIT_CD: if (cd_active) next = HUNT; else if (timer_last) next = DONE;
            HUNT:    if (!cd_active) next = DONE; else if (SD == SD_START) next = DATA;
            DATA:    if (!cd_active) next = DONE; else if (bit_last) next = HUNT;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // CD wins over data in both HUNT and DATA: a rising CD ends the transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trd_q       <= 1'b0;
            timer       <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            wr_ptr      <= '0;
            byte_count  <= '0;
            overflow    <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            trd_q <= TRD;
            if (state == REQ) begin
                timer       <= '0;
                wr_ptr      <= '0;
                byte_count  <= '0;
                overflow    <= 1'b0;
                frame_err   <= 1'b0;
                timeout_err <= 1'b0;
            end else if (state == WAIT_CD) begin
                timer <= timer + 1'b1;
                if (!cd_active && timer_last)
                    timeout_err <= 1'b1;
            end else if (state == HUNT) begin
                bit_cnt <= '0;
            end else if (state == DATA) begin
                if (!cd_active) begin
                    frame_err <= 1'b1;
                end else begin
                    shreg   <= {SD, shreg[6:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_last && full) begin
                        overflow <= 1'b1;
                    end else if (bit_last) begin
                        wr_ptr     <= wr_ptr + 1'b1;
                        byte_count <= byte_count + 1'b1;
                    end
                end
            end
        end
    end

    rx_buffer_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_tsc_hub_rx.sv
// tb_tsc_hub_rx: directed self-checking bench for tsc_hub_rx
module tb_tsc_hub_rx;

    logic       clk = 1'b0;
    logic       reset, en, TRD, SD, CD;
    logic [4:0] rd_addr;
    logic       SBF, busy, frame_done, overflow, frame_err, timeout_err;
    logic [7:0] rd_data;
    logic [5:0] byte_count;

    int checks = 0;
    int fails  = 0;
    int sbf_cnt = 0;

    tsc_hub_rx dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .TRD         (TRD),
        .SD          (SD),
        .CD          (CD),
        .SBF         (SBF),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .byte_count  (byte_count),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .frame_err   (frame_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (SBF === 1'b1) sbf_cnt <= sbf_cnt + 1;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        SD = 1'b0;
        step;
        for (int i = 0; i < 8; i++) begin
            SD = v[i];
            step;
        end
        SD = 1'b1;
    endtask

    task automatic begin_xfer(output logic sbf_seen);
        TRD = 1'b1;
        step;
        sbf_seen = SBF;
        CD = 1'b0;
        step;
        step;
    endtask

    task automatic read_buf(input logic [4:0] a, output logic [7:0] d);
        rd_addr = a;
        step;
        d = rd_data;
    endtask

    task automatic test_reset;
        reset = 1'b1; en = 1'b1; TRD = 1'b0; SD = 1'b1; CD = 1'b1; rd_addr = '0;
        step;
        step;
        checks++;
        if ({SBF, busy, frame_done, overflow, frame_err, timeout_err} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000000", {SBF, busy, frame_done, overflow, frame_err, timeout_err});
        end
        checks++;
        if (byte_count !== 6'd0) begin fails++; $display("FAIL reset_byte_count: got %0d expected 0", byte_count); end
        checks++;
        if (rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
        reset = 1'b0;
        step;
    endtask

    task automatic test_enable;
        int s0;
        s0 = sbf_cnt;
        en = 1'b0;
        TRD = 1'b1;
        step;
        step;
        checks++;
        if (busy !== 1'b0 || sbf_cnt != s0) begin
            fails++;
            $display("FAIL enable_gate: busy %b sbf pulses %0d expected busy 0 pulses 0", busy, sbf_cnt - s0);
        end
        TRD = 1'b0;
        en = 1'b1;
        step;
    endtask

    task automatic test_single_byte;
        logic seen;
        logic [7:0] d;
        int s0;
        s0 = sbf_cnt;
        begin_xfer(seen);
        checks++;
        if (seen !== 1'b1) begin fails++; $display("FAIL single_sbf: got %b expected 1", seen); end
        send_byte(8'hA5);
        checks++;
        if (byte_count !== 6'd1) begin fails++; $display("FAIL single_count: got %0d expected 1", byte_count); end
        CD = 1'b1;
        step;
        checks++;
        if (frame_done !== 1'b1) begin fails++; $display("FAIL single_done: got %b expected 1", frame_done); end
        checks++;
        if ({overflow, frame_err, timeout_err} !== 3'b000) begin
            fails++;
            $display("FAIL single_flags: got %b expected 000", {overflow, frame_err, timeout_err});
        end
        step;
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: frame_done %b busy %b expected 0 0", frame_done, busy);
        end
        checks++;
        if (sbf_cnt - s0 != 1) begin fails++; $display("FAIL single_sbf_pulses: got %0d expected 1", sbf_cnt - s0); end
        TRD = 1'b0;
        read_buf(5'd0, d);
        checks++;
        if (d !== 8'hA5) begin fails++; $display("FAIL single_buf0: got %h expected a5", d); end
    endtask

    task automatic test_full_buffer;
        logic seen;
        logic [7:0] d;
        begin_xfer(seen);
        for (int i = 0; i < 32; i++) send_byte(8'(i));
        checks++;
        if (byte_count !== 6'd32 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_count: count %0d overflow %b expected 32 0", byte_count, overflow);
        end
        send_byte(8'hFF);
        checks++;
        if (byte_count !== 6'd32 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL full_overflow: count %0d overflow %b expected 32 1", byte_count, overflow);
        end
        CD = 1'b1;
        step;
        checks++;
        if (frame_done !== 1'b1) begin fails++; $display("FAIL full_done: got %b expected 1", frame_done); end
        step;
        TRD = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_buf(5'(i), d);
            checks++;
            if (d !== 8'(i)) begin fails++; $display("FAIL full_buf[%0d]: got %h expected %h", i, d, 8'(i)); end
        end
    endtask

    task automatic test_timeout;
        int n;
        TRD = 1'b1;
        step;
        checks++;
        if (SBF !== 1'b1) begin fails++; $display("FAIL timeout_sbf: got %b expected 1", SBF); end
        n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            step;
            n++;
        end
        checks++;
        if (n != 65) begin fails++; $display("FAIL timeout_latency: got %0d cycles expected 65", n); end
        checks++;
        if (timeout_err !== 1'b1 || byte_count !== 6'd0) begin
            fails++;
            $display("FAIL timeout_flags: timeout_err %b count %0d expected 1 0", timeout_err, byte_count);
        end
        step;
        TRD = 1'b0;
        step;
    endtask

    task automatic test_broken_byte;
        logic seen;
        logic [7:0] d;
        begin_xfer(seen);
        checks++;
        if (timeout_err !== 1'b0) begin fails++; $display("FAIL broken_sticky_clear: got %b expected 0", timeout_err); end
        send_byte(8'h3C);
        SD = 1'b0;
        step;
        for (int i = 0; i < 4; i++) begin
            SD = 1'(i & 1);
            step;
        end
        CD = 1'b1;
        SD = 1'b1;
        step;
        checks++;
        if (frame_done !== 1'b1 || frame_err !== 1'b1 || byte_count !== 6'd1) begin
            fails++;
            $display("FAIL broken_end: frame_done %b frame_err %b count %0d expected 1 1 1", frame_done, frame_err, byte_count);
        end
        step;
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL broken_idle: busy %b expected 0", busy); end
        TRD = 1'b0;
        read_buf(5'd0, d);
        checks++;
        if (d !== 8'h3C) begin fails++; $display("FAIL broken_buf0: got %h expected 3c", d); end
        read_buf(5'd1, d);
        checks++;
        if (d !== 8'h01) begin fails++; $display("FAIL broken_buf1: got %h expected 01", d); end
    endtask

    task automatic test_rearm;
        logic seen;
        int s0;
        begin_xfer(seen);
        send_byte(8'h5A);
        SD = 1'b0;
        step;
        SD = 1'b1;
        step;
        CD = 1'b1;
        step;
        step;
        s0 = sbf_cnt;
        repeat (10) step;
        checks++;
        if (sbf_cnt != s0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rearm_held: sbf pulses %0d busy %b expected 0 0", sbf_cnt - s0, busy);
        end
        TRD = 1'b0;
        step;
        TRD = 1'b1;
        step;
        checks++;
        if (SBF !== 1'b1) begin fails++; $display("FAIL rearm_sbf: got %b expected 1", SBF); end
        step;
        checks++;
        if (frame_err !== 1'b0) begin fails++; $display("FAIL rearm_clear: frame_err %b expected 0", frame_err); end
        CD = 1'b0;
        step;
        CD = 1'b1;
        step;
        checks++;
        if (frame_done !== 1'b1 || byte_count !== 6'd0) begin
            fails++;
            $display("FAIL rearm_done: frame_done %b count %0d expected 1 0", frame_done, byte_count);
        end
        step;
        TRD = 1'b0;
        step;
    endtask

    task automatic test_reset_mid_data;
        logic seen;
        logic [7:0] d;
        begin_xfer(seen);
        SD = 1'b0;
        step;
        for (int i = 0; i < 3; i++) begin
            SD = 1'b1;
            step;
        end
        SD = 1'b0;
        #2;
        TRD = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if ({SBF, busy, frame_done, overflow, frame_err, timeout_err} !== 6'b0 || byte_count !== 6'd0 || rd_data !== 8'h00) begin
            fails++;
            $display("FAIL midreset_outputs: flags %b count %0d rd_data %h expected 000000 0 00",
                     {SBF, busy, frame_done, overflow, frame_err, timeout_err}, byte_count, rd_data);
        end
        step;
        reset = 1'b0;
        step;
        CD = 1'b0;
        send_byte(8'hFF);
        send_byte(8'h00);
        CD = 1'b1;
        step;
        checks++;
        if (busy !== 1'b0 || byte_count !== 6'd0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL midreset_ignore: busy %b count %0d frame_done %b expected 0 0 0", busy, byte_count, frame_done);
        end
        read_buf(5'd0, d);
        checks++;
        if (d !== 8'h5A) begin fails++; $display("FAIL midreset_buf0: got %h expected 5a", d); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_enable;
        test_single_byte;
        test_full_buffer;
        test_timeout;
        test_broken_byte;
        test_rearm;
        test_reset_mid_data;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/tsc_hub_rx.md
# tsc_hub_rx

Hub-side receiver for the TSC capture link. Detects the TSC's capture-ready flag (TRD), issues a one-cycle send-buffer request (SBF), then deserializes the byte stream on SD into a local 32-entry buffer until the completed-data line (CD) returns high. Sits in the hub, sharing `clk` with the TSC. The TSC drives SD/CD on `negedge clk`; this block samples on `posedge clk`, so no synchronizer is required.

## Interface
- `DEPTH`, 32: receive buffer entries (power of two).
- `ADDR_W`, 5: log2(DEPTH).
- `CD_TIMEOUT`, 64: max cycles from SBF until CD is seen low.
- `clk`  in  1  system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-high; clock `clk`.
- `en`  in  1  arms the receiver; with `en`=0, TRD is ignored.
- `TRD`  in  1  TSC capture complete, level.
- `SD`  in  1  serial data, idle high.
- `CD`  in  1  completed-data line; low while the TSC is sending.
- `SBF`  out  1  send-buffer request, one-cycle pulse.
- `rd_addr`  in  ADDR_W  buffer read address.
- `rd_data`  out  8  buffer contents at `rd_addr`, registered.
- `byte_count`  out  ADDR_W+1  bytes stored in the current transfer, 0..DEPTH.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse at transfer end.
- `overflow`  out  1  sticky; a byte arrived with the buffer full.
- `frame_err`  out  1  sticky; CD rose mid-byte.
- `timeout_err`  out  1  sticky; CD did not fall within CD_TIMEOUT.

## Operation
- Line format: SD idle high. Each byte is a start bit (0) followed by 8 data bits, LSB first, one bit per clk. Bytes are back-to-back. CD high marks the end of the transfer.
- States: IDLE, REQ, WAIT_CD, HUNT, DATA, DONE.
- IDLE:
  - Register TRD every cycle.
  - On a TRD rising edge with `en`=1, go to REQ.
- REQ:
  - SBF=1 for exactly this cycle.
  - Clear `byte_count`, `wr_ptr`, and all sticky flags.
  - Go to WAIT_CD.
- WAIT_CD:
  - If CD is sampled low, go to HUNT.
  - After CD_TIMEOUT cycles, set `timeout_err` and go to DONE.
- HUNT:
  - If CD is sampled high, go to DONE.
  - Else if SD is sampled low, treat it as the start bit: `bit_cnt`=0, go to DATA.
  - Else stay (SD high).
- DATA:
  - Shift in SD at bit position `bit_cnt`.
  - After bit 7, write the byte to `buf[wr_ptr]` if `byte_count` < DEPTH, then increment `wr_ptr` and `byte_count`.
  - If the buffer is full, discard the byte and set `overflow`.
  - Return to HUNT.
  - If CD is sampled high during DATA, discard the partial byte, set `frame_err`, and go to DONE.
- DONE:
  - `frame_done`=1 for one cycle, then go to IDLE.
  - `byte_count` and buffer contents hold until the next REQ.
- TRD is edge-detected. A TRD held high after DONE does not re-request; it must fall and rise again.
- `wr_ptr` wraps modulo DEPTH. `byte_count` saturates at DEPTH.

## Timing
- Reset values:
  - SBF=0, `rd_data`=0, `byte_count`=0, `busy`=0, `frame_done`=0, and all sticky flags 0.
  - State=IDLE, TRD history=0.
  - Buffer contents are not reset.
- Reset asserted mid-transfer returns the block to IDLE immediately. Any SD activity after reset is ignored until a new TRD rising edge.
- TRD rising at posedge N is detected at N. SBF is high in cycle N+1 and `busy` goes high at N+1.
- The start bit sampled at posedge S means data bit k is sampled at S+1+k. The byte is written and `byte_count` increments at S+8 (visible from S+9).
- `rd_data` has 1-cycle latency from `rd_addr`. A read and a write to the same address in the same cycle return the old data.
- If CD goes high and SD goes low on the same sample in HUNT, CD wins: go to DONE.

## Structure
- A shared package `tsc_link_pkg` holds:
  - the state enum;
  - the line constants SD_IDLE=1, SD_START=0, CD_ACTIVE=0, BITS_PER_BYTE=8;
  - the default DEPTH. The TSC-side sender should reuse the same constants.
- One sub-module, `rx_buffer_ram`: DEPTH×8, single write port, registered read port.
- The FSM, deserializer, and counters stay in the top module.

## Test plan
- Single byte: TRD rises, then the TSC sends start + 0xA5 LSB first, then CD goes high. Expect SBF one pulse at TRD+1, `buf[0]`=0xA5, `byte_count`=1, `frame_done` pulse, no flags set.
- Full buffer: 32 back-to-back bytes 0x00..0x1F. Expect `buf[i]`=i, `byte_count`=32, `overflow`=0. A 33rd byte 0xFF sets `overflow`, leaves `buf[0]`=0x00, and `byte_count` stays 32.
- No response: CD is held high after SBF. Expect `timeout_err`=1 after 64 cycles, `frame_done` pulse, `byte_count`=0.
- Broken byte: CD rises after 4 data bits of the second byte. Expect `byte_count`=1, `frame_err`=1, state IDLE.
- TRD re-arm: TRD is held high through DONE. Expect no second SBF. TRD falls then rises: expect SBF again, with sticky flags cleared in REQ.
- Reset mid-DATA: assert reset during bit 3. Expect all outputs at reset values next cycle, and no write on subsequent SD toggles.
